mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 144 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with halt and fault states.
// Optional memory-wait watchdog enabled by defining MC_CTRL_TIMEOUT_EN.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_ready,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             dec_regwen,
    input  logic             halt_req,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             store_q;
    logic             regwen_q;
    logic             in_access;
    logic             timeout;

    assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // ---- stage p0: state and retired-instruction registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WB)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Instruction class is captured at EXEC so MEM/WB strobes stay Moore and stable.
    always_ff @(posedge clk) begin
        if (state_q == ST_EXEC) begin
            store_q  <= is_store;
            regwen_q <= dec_regwen;
        end
    end

`ifdef MC_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt_q;

    // Any cycle outside a stalled access clears the counter, so it is zero on every FETCH/MEM entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_q <= 8'd0;
        else if (in_access && !mem_ready)
            wait_cnt_q <= wait_cnt_q + 8'd1;
        else
            wait_cnt_q <= 8'd0;
    end

    assign timeout = in_access && !mem_ready && (wait_cnt_q == 8'(MEM_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // ---- stage p1: next-state decode ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready)
                    state_d = ST_DECODE;
                else if (timeout)
                    state_d = ST_FAULT;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = (is_load || is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ready)
                    state_d = ST_WB;
                else if (timeout)
                    state_d = ST_FAULT;
            end
            ST_WB:     state_d = halt_req ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = halt_req ? ST_HALTED : ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    // ---- stage p2: output decode; ir_we/mdr_we are the only Mealy strobes ----
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = store_q;
                    mdr_we   = mem_ready && !store_q;
                end
                ST_WB: begin
                    pc_we = 1'b1;
                    rf_we = regwen_q;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == ST_HALTED);
    assign fault   = (state_q == ST_FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (counter width reduced to 4 to reach wrap quickly).
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_ready, is_load, is_store, dec_regwen, halt_req;
    logic             mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, rf_we;
    logic [2:0]       state;
    logic             halted, fault;
    logic [CNT_W-1:0] instret;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_instret;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .is_load(is_load),
        .is_store(is_store), .dec_regwen(dec_regwen), .halt_req(halt_req),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .pc_we(pc_we), .rf_we(rf_we), .state(state),
        .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one ALU instruction starting at a FETCH cycle with zero-wait memory.
    task automatic alu_instr(input logic regwen, input logic halt);
        is_load = 1'b0; is_store = 1'b0; dec_regwen = regwen;
        mem_ready = 1'b1; halt_req = 1'b0;
        #1;
        check("alu_fetch_state", state, 3'd0);
        check("alu_fetch_ir_we", ir_we, 1'b1);
        tick();
        check("alu_decode_state", state, 3'd1);
        check("alu_decode_ir_we", ir_we, 1'b0);
        tick();
        check("alu_exec_state", state, 3'd2);
        halt_req = halt;
        tick();
        check("alu_wb_state", state, 3'd4);
        check("alu_wb_pc_we", pc_we, 1'b1);
        check("alu_wb_rf_we", rf_we, regwen);
        tick();
        exp_instret = exp_instret + 1'b1;
        check("alu_instret", instret, exp_instret);
        if (halt) begin
            check("halt_state", state, 3'd5);
            check("halt_halted", halted, 1'b1);
            check("halt_mem_req", mem_req, 1'b0);
        end else begin
            check("alu_next_state", state, 3'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; is_load = 1'b0; is_store = 1'b0;
        dec_regwen = 1'b0; halt_req = 1'b0;
        exp_instret = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 3'd0);
        check("rst_instret", instret, 4'd0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_ir_we", ir_we, 1'b0);
        check("rst_pc_we", pc_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_mem_req", mem_req, 1'b1);

        alu_instr(1'b1, 1'b0);

        // Load with three wait cycles in MEM
        is_load = 1'b1; mem_ready = 1'b1;
        #1 check("ld_fetch_ir_we", ir_we, 1'b1);
        tick(); tick();
        check("ld_exec_state", state, 3'd2);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_state", state, 3'd3);
            check("ld_wait_mem_req", mem_req, 1'b1);
            check("ld_wait_addr_sel", addr_sel, 1'b1);
            check("ld_wait_mdr_we", mdr_we, 1'b0);
            check("ld_wait_mem_we", mem_we, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ld_done_state", state, 3'd3);
        check("ld_done_mem_req", mem_req, 1'b1);
        check("ld_done_mdr_we", mdr_we, 1'b1);
        tick();
        check("ld_wb_state", state, 3'd4);
        check("ld_wb_mdr_we", mdr_we, 1'b0);
        tick();
        exp_instret = exp_instret + 1'b1;
        check("ld_next_state", state, 3'd0);
        check("ld_instret", instret, exp_instret);

        // Store without register write
        is_load = 1'b0; is_store = 1'b1; dec_regwen = 1'b0; mem_ready = 1'b1;
        #1 check("st_fetch_mem_we", mem_we, 1'b0);
        tick(); tick();
        check("st_exec_mem_we", mem_we, 1'b0);
        tick();
        check("st_mem_state", state, 3'd3);
        check("st_mem_mem_we", mem_we, 1'b1);
        check("st_mem_mdr_we", mdr_we, 1'b0);
        tick();
        check("st_wb_rf_we", rf_we, 1'b0);
        check("st_wb_pc_we", pc_we, 1'b1);
        check("st_wb_mem_we", mem_we, 1'b0);
        tick();
        exp_instret = exp_instret + 1'b1;
        check("st_instret", instret, exp_instret);

        // Load and store both set behaves as a store
        is_load = 1'b1; is_store = 1'b1;
        tick(); tick(); tick();
        check("ldst_mem_we", mem_we, 1'b1);
        check("ldst_mdr_we", mdr_we, 1'b0);
        tick(); tick();
        exp_instret = exp_instret + 1'b1;
        check("ldst_state", state, 3'd0);

        // Halt at WB, hold, then resume
        alu_instr(1'b1, 1'b1);
        tick();
        check("halt_hold_state", state, 3'd5);
        check("halt_hold_pc_we", pc_we, 1'b0);
        halt_req = 1'b0;
        tick();
        check("resume_state", state, 3'd0);
        check("resume_halted", halted, 1'b0);

        is_load = 1'b0; is_store = 1'b0; dec_regwen = 1'b1;
`ifdef MC_CTRL_TIMEOUT_EN
        mem_ready = 1'b0;
        repeat (15) tick();
        check("to15_state", state, 3'd0);
        check("to15_fault", fault, 1'b0);
        tick();
        check("to16_state", state, 3'd6);
        check("to16_fault", fault, 1'b1);
        mem_ready = 1'b1; halt_req = 1'b1;
        repeat (3) tick();
        check("fault_sticky_state", state, 3'd6);
        check("fault_sticky_fault", fault, 1'b1);
        check("fault_mem_req", mem_req, 1'b0);
        check("fault_halted", halted, 1'b0);
        halt_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("fault_rst_state", state, 3'd0);
        check("fault_rst_fault", fault, 1'b0);
        tick();
        rst_n = 1'b1;
        exp_instret = '0;
        mem_ready = 1'b0;
        repeat (15) tick();
        mem_ready = 1'b1;
        #1 check("to_win_ir_we", ir_we, 1'b1);
        tick();
        check("to_win_state", state, 3'd1);
        check("to_win_fault", fault, 1'b0);
`else
        mem_ready = 1'b0;
        repeat (20) tick();
        check("wait_state", state, 3'd0);
        check("wait_fault", fault, 1'b0);
        check("wait_ir_we", ir_we, 1'b0);
        check("wait_mem_req", mem_req, 1'b1);
        mem_ready = 1'b1;
        #1 check("wait_done_ir_we", ir_we, 1'b1);
        tick();
        check("wait_done_state", state, 3'd1);
`endif
        tick(); tick(); tick();
        exp_instret = exp_instret + 1'b1;
        check("post_wait_state", state, 3'd0);
        check("post_wait_instret", instret, exp_instret);

        // Counter wrap
        while (exp_instret != 4'hF) alu_instr(1'b1, 1'b0);
        check("pre_wrap_instret", instret, 4'hF);
        alu_instr(1'b1, 1'b0);
        check("wrap_instret", instret, 4'h0);
        alu_instr(1'b0, 1'b0);

        // Asynchronous reset during a stalled store access
        is_store = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        #1 check("mid_mem_we", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_instret", instret, 4'd0);
        check("arst_mem_we", mem_we, 1'b0);
        check("arst_mem_req", mem_req, 1'b0);
        tick();
        rst_n = 1'b1;
        exp_instret = '0;
        alu_instr(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
